// File: rtl/serial_shifter.sv
// ============================================================================
// Module   : serial_shifter
// Function : Bit-serial 16-bit shift engine (SLL/SRA/ROR/ROL), one position
//            per clock, with a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Shift_In,
  input  logic [CNT_W-1:0] Shift_Val,
  input  logic [1:0]       Mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Shift_Out
);

  localparam logic [1:0] c_MODE_SLL = 2'b00;
  localparam logic [1:0] c_MODE_SRA = 2'b01;
  localparam logic [1:0] c_MODE_ROR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic [WIDTH-1:0] w_step;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;

  always_comb begin
    case (r_mode)
      c_MODE_SLL: w_step = {r_work[WIDTH-2:0], 1'b0};
      c_MODE_SRA: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      c_MODE_ROR: w_step = {r_work[0], r_work[WIDTH-1:1]};
      default:    w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_count_nxt = r_count;
    w_mode_nxt  = r_mode;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_work_nxt  = Shift_In;
          w_count_nxt = Shift_Val;
          w_mode_nxt  = Mode;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The count==0 cycle publishes the result rather than shifting, which
        // is what makes the latency Shift_Val+2 including the DONE cycle.
        if (r_count == '0) begin
          w_out_nxt   = r_work;
          w_state_nxt = S_DONE;
        end else begin
          w_work_nxt  = w_step;
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_count <= '0;
      r_mode  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_count <= w_count_nxt;
      r_mode  <= w_mode_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign Shift_Out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: directed vector table, multi-cycle
// corner sequences and a bounded random sweep against a behavioural model.
`default_nettype none

module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] Shift_In;
  logic [3:0]  Shift_Val;
  logic [1:0]  Mode;
  logic        busy;
  logic        done;
  logic [15:0] Shift_Out;

  int checks = 0;
  int errors = 0;

  serial_shifter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Shift_In  (Shift_In),
    .Shift_Val (Shift_Val),
    .Mode      (Mode),
    .busy      (busy),
    .done      (done),
    .Shift_Out (Shift_Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] din;
    logic [3:0]  val;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; returns the result and the edge count until done is seen.
  task automatic run_op(input logic [1:0] m, input logic [15:0] d, input logic [3:0] v,
                        output logic [15:0] res, output int lat);
    Mode      = m;
    Shift_In  = d;
    Shift_Val = v;
    start     = 1'b1;
    lat       = 0;
    tick();
    lat   = 1;
    start = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    res = Shift_Out;
    tick();
  endtask

  function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] x, input int v);
    logic [31:0] dbl;
    dbl = {x, x};
    case (m)
      2'b00:   model = x << v;
      2'b01:   model = 16'($signed(x) >>> v);
      2'b10:   model = 16'(dbl >> v);
      default: model = 16'((dbl << v) >> 16);
    endcase
  endfunction

  initial begin
    vec_t        vecs[12];
    logic [15:0] res;
    int          lat;
    int          ndone;

    vecs[0]  = '{2'b00, 16'h0001, 4'd4,  16'h0010};
    vecs[1]  = '{2'b01, 16'h8000, 4'd15, 16'hFFFF};
    vecs[2]  = '{2'b01, 16'h7FF0, 4'd4,  16'h07FF};
    vecs[3]  = '{2'b10, 16'h0001, 4'd1,  16'h8000};
    vecs[4]  = '{2'b11, 16'h8001, 4'd4,  16'h0018};
    vecs[5]  = '{2'b00, 16'hA5A5, 4'd0,  16'hA5A5};
    vecs[6]  = '{2'b01, 16'hA5A5, 4'd0,  16'hA5A5};
    vecs[7]  = '{2'b10, 16'hA5A5, 4'd0,  16'hA5A5};
    vecs[8]  = '{2'b11, 16'hA5A5, 4'd0,  16'hA5A5};
    vecs[9]  = '{2'b10, 16'h1234, 4'd4,  16'h4123};
    vecs[10] = '{2'b11, 16'h1234, 4'd4,  16'h2341};
    vecs[11] = '{2'b10, 16'h8001, 4'd15, 16'h0003};

    rst = 1'b1; start = 1'b0; Shift_In = '0; Shift_Val = '0; Mode = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out",  32'(Shift_Out), 32'd0);

    // First op by hand: busy after accept and busy low after done.
    Mode = 2'b00; Shift_In = 16'h0001; Shift_Val = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("sll_busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("sll_latency", 32'(lat), 32'd6);
    check("sll_result", 32'(Shift_Out), 32'h0010);
    tick();
    check("sll_busy_after_done", 32'(busy), 32'd0);
    check("sll_done_cleared", 32'(done), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].mode, vecs[i].din, vecs[i].val, res, lat);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].val) + 32'd2);
    end

    // Operands and start churn while busy must not disturb the accepted op.
    Mode = 2'b00; Shift_In = 16'h00FF; Shift_Val = 4'd8; start = 1'b1;
    tick();
    Shift_In = 16'hFFFF; Mode = 2'b11; Shift_Val = 4'd3;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      if (done) ndone++;
      if (!busy) start = 1'b0;
      tick();
    end
    check("churn_done_count", 32'(ndone), 32'd1);
    check("churn_result", 32'(Shift_Out), 32'hFF00);
    check("churn_idle", 32'(busy), 32'd0);

    // Reset three cycles into a 10-step shift.
    Mode = 2'b00; Shift_In = 16'h0001; Shift_Val = 4'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out",  32'(Shift_Out), 32'd0);
    run_op(2'b00, 16'h0001, 4'd10, res, lat);
    check("post_rst_result", 32'(res), 32'h0400);
    check("post_rst_latency", 32'(lat), 32'd12);

    for (int n = 0; n < 1000; n++) begin
      logic [1:0]  m;
      logic [15:0] d;
      logic [3:0]  v;
      int          e0;
      m = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      v = 4'($urandom_range(0, 15));
      e0 = errors;
      run_op(m, d, v, res, lat);
      check($sformatf("rand%0d_m%0d_v%0d_d%h", n, m, v, d), 32'(res), 32'(model(m, d, int'(v))));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(v) + 32'd2);
      if (errors != e0) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
